mdr_result_bcd: RTL and testbench

Output stage placed directly downstream of the multiply/divide/root unit (`mdr`). When `mdr` presents a result, this block captures it along with the remainder and error flag. It converts the signed result, or the unsigned remainder, to sign-plus-BCD using a sequential double-dabble, one bit per clock. The BCD digits drive the board display logic.

---
 rtl/mdr_result_bcd.sv | 128 ++++++++++++
 tb/tb_mdr_result_bcd.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_result_bcd.sv
// Captures an mdr result/remainder and converts it to sign + BCD by serial double-dabble.
// Latency: o_done pulses DW+1 cycles after capture (1 cycle on the error path).
// Backpressure: none; i_valid is ignored while o_busy is high, upstream waits for o_done.
module mdr_result_bcd #(
    parameter int DW     = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DW-1:0]         i_result,
    input  logic [DW-1:0]         i_reminder,
    input  logic                  i_error,
    input  logic                  i_show_rem,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_sign,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_err
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [DW-1:0]   r_mag;
    logic [BW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_psign;
    logic            r_done;
    logic            r_sign;
    logic            r_err;
    logic [BW-1:0]   r_bcd;

    logic            w_accept;
    logic [DW-1:0]   w_abs;
    logic [BW-1:0]   w_adj;

    // The o_done cycle still counts as busy, so a request arriving with o_done is dropped.
    assign w_accept = (r_state == S_IDLE) && i_valid && !r_done;
    assign w_abs    = i_result[DW-1] ? (~i_result + 1'b1) : i_result;

    assign o_busy = (r_state != S_IDLE) || r_done;
    assign o_done = r_done;
    assign o_sign = r_sign;
    assign o_bcd  = r_bcd;
    assign o_err  = r_err;

    // Double-dabble correction: every digit of 5 or more gets +3 before the shift.
    always_comb begin
        w_adj = r_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = i_error ? S_ERR : S_SHIFT;
            S_SHIFT: if (r_cnt == CW'(1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Conversion datapath and display registers; display only updates in DONE/ERR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mag   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_psign <= 1'b0;
            r_done  <= 1'b0;
            r_sign  <= 1'b0;
            r_err   <= 1'b0;
            r_bcd   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && !i_error) begin
                        r_mag   <= i_show_rem ? i_reminder : w_abs;
                        r_psign <= i_result[DW-1] & ~i_show_rem;
                        r_acc   <= '0;
                        r_cnt   <= CW'(DW);
                    end
                end
                S_SHIFT: begin
                    r_acc <= {w_adj[BW-2:0], r_mag[DW-1]};
                    r_mag <= {r_mag[DW-2:0], 1'b0};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_DONE: begin
                    r_bcd  <= r_acc;
                    r_sign <= r_psign;
                    r_err  <= 1'b0;
                    r_done <= 1'b1;
                end
                S_ERR: begin
                    r_bcd  <= {DIGITS{4'hF}};
                    r_sign <= 1'b0;
                    r_err  <= 1'b1;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_result_bcd.sv
// Directed bench for mdr_result_bcd (DW=16, DIGITS=5).
// Inputs change 1ns after the rising edge; outputs are sampled at that point too.
// Each scenario task performs and counts its own comparisons.
module tb_mdr_result_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_result = '0;
    logic [15:0] i_reminder = '0;
    logic        i_error = 1'b0;
    logic        i_show_rem = 1'b0;
    logic        o_busy, o_done, o_sign, o_err;
    logic [19:0] o_bcd;

    int checks = 0;
    int errors = 0;

    mdr_result_bcd #(.DW(16), .DIGITS(5)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_result(i_result),
        .i_reminder(i_reminder), .i_error(i_error), .i_show_rem(i_show_rem),
        .o_busy(o_busy), .o_done(o_done), .o_sign(o_sign), .o_bcd(o_bcd), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Present one request; returns 1ns after the capture edge with i_valid dropped.
    task automatic start(input logic [15:0] res, input logic [15:0] rem,
                         input logic show, input logic err);
        i_result = res; i_reminder = rem; i_show_rem = show; i_error = err;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_result = 16'h5A5A; i_reminder = 16'hA5A5; i_error = 1'b0; i_show_rem = 1'b0;
    endtask

    // Counts edges until o_done is seen; lat = -1 if it never arrives within 40 cycles.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (!o_busy) busy_ok = 1'b0;
            if (o_done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_busy, o_done, o_sign, o_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {o_busy, o_done, o_sign, o_err});
        end
        checks++;
        if (o_bcd !== 20'h00000) begin
            errors++; $display("FAIL reset_bcd got %h want 00000", o_bcd);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_positive();
        int lat; logic bok;
        start(16'd25, 16'd0, 1'b0, 1'b0);
        wait_done(lat, bok);
        checks++;
        if (lat !== 17) begin errors++; $display("FAIL pos_latency got %0d want 17", lat); end
        checks++;
        if (bok !== 1'b1) begin errors++; $display("FAIL pos_busy got %b want 1", bok); end
        checks++;
        if ({o_bcd, o_sign, o_err} !== {20'h00025, 2'b00}) begin
            errors++; $display("FAIL pos_value got %h/%b/%b want 00025/0/0", o_bcd, o_sign, o_err);
        end
        @(posedge clk); #1;
        checks++;
        if ({o_done, o_busy} !== 2'b00) begin
            errors++; $display("FAIL pos_after got done/busy %b want 00", {o_done, o_busy});
        end
    endtask

    task automatic test_negative();
        int lat; logic bok;
        // -1234; display must hold the previous 00025 during the conversion
        start(16'hFB2E, 16'd0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (o_bcd !== 20'h00025 || o_done !== 1'b0) begin
            errors++; $display("FAIL neg_hold got %h done %b want 00025 done 0", o_bcd, o_done);
        end
        wait_done(lat, bok);
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL neg_latency got %0d want 12", lat); end
        checks++;
        if ({o_bcd, o_sign} !== {20'h01234, 1'b1}) begin
            errors++; $display("FAIL neg_1234 got %h/%b want 01234/1", o_bcd, o_sign);
        end
        @(posedge clk); #1;
        start(16'h8000, 16'd0, 1'b0, 1'b0);
        wait_done(lat, bok);
        checks++;
        if ({o_bcd, o_sign} !== {20'h32768, 1'b1}) begin
            errors++; $display("FAIL neg_min got %h/%b want 32768/1", o_bcd, o_sign);
        end
        @(posedge clk); #1;
        start(16'h0000, 16'd0, 1'b0, 1'b0);
        wait_done(lat, bok);
        checks++;
        if ({o_bcd, o_sign} !== {20'h00000, 1'b0}) begin
            errors++; $display("FAIL zero got %h/%b want 00000/0", o_bcd, o_sign);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_remainder();
        int lat; logic bok;
        start(16'hFFFD, 16'd7, 1'b1, 1'b0);
        wait_done(lat, bok);
        checks++;
        if ({o_bcd, o_sign} !== {20'h00007, 1'b0}) begin
            errors++; $display("FAIL rem_7 got %h/%b want 00007/0", o_bcd, o_sign);
        end
        @(posedge clk); #1;
        start(16'h0001, 16'hFFFF, 1'b1, 1'b0);
        wait_done(lat, bok);
        checks++;
        if ({o_bcd, o_sign} !== {20'h65535, 1'b0}) begin
            errors++; $display("FAIL rem_ffff got %h/%b want 65535/0", o_bcd, o_sign);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_error();
        int lat; logic bok;
        start(16'hFFF0, 16'h1234, 1'b0, 1'b1);
        wait_done(lat, bok);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL err_latency got %0d want 1", lat); end
        checks++;
        if ({o_bcd, o_sign, o_err, o_busy} !== {20'hFFFFF, 3'b011}) begin
            errors++; $display("FAIL err_value got %h/%b/%b busy %b want FFFFF/0/1 busy 1",
                               o_bcd, o_sign, o_err, o_busy);
        end
        @(posedge clk); #1;
        start(16'd5, 16'd0, 1'b0, 1'b0);
        wait_done(lat, bok);
        checks++;
        if ({o_bcd, o_err} !== {20'h00005, 1'b0}) begin
            errors++; $display("FAIL err_clear got %h/%b want 00005/0", o_bcd, o_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overlap();
        int first = -1;
        int pulses = 0;
        start(16'd25, 16'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 45; k++) begin
            if (k == 5) begin i_result = 16'd99; i_valid = 1'b1; end
            @(posedge clk); #1;
            i_valid = 1'b0;
            if (o_done) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL ovl_pulses got %0d want 1", pulses); end
        checks++;
        if (first !== 17) begin errors++; $display("FAIL ovl_latency got %0d want 17", first); end
        checks++;
        if (o_bcd !== 20'h00025) begin errors++; $display("FAIL ovl_value got %h want 00025", o_bcd); end
    endtask

    task automatic test_back_to_back();
        int lat; logic bok; int pulses = 0;
        // i_valid raised in the o_done cycle must be dropped
        start(16'd77, 16'd0, 1'b0, 1'b0);
        wait_done(lat, bok);
        i_result = 16'd88; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (o_done) pulses++;
        end
        checks++;
        if (pulses !== 0 || o_bcd !== 20'h00077) begin
            errors++; $display("FAIL b2b_drop got pulses %0d bcd %h want 0 00077", pulses, o_bcd);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic bok; int pulses = 0;
        start(16'hFB2E, 16'd0, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if ({o_busy, o_done, o_sign, o_err, o_bcd} !== 24'h0) begin
            errors++; $display("FAIL mid_reset got busy %b done %b sign %b err %b bcd %h want all 0",
                               o_busy, o_done, o_sign, o_err, o_bcd);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (o_done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL mid_nodone got %0d want 0", pulses); end
        start(16'd42, 16'd0, 1'b0, 1'b0);
        wait_done(lat, bok);
        checks++;
        if (lat !== 17 || o_bcd !== 20'h00042) begin
            errors++; $display("FAIL mid_recover got lat %0d bcd %h want 17 00042", lat, o_bcd);
        end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_remainder();
        test_error();
        test_overlap();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
